// File: rtl/data_mem_arbiter_if.sv
// Bus bundle around the shared data-RAM port: CPU Memory-stage side, host
// loader/readout side and the RAM itself.
interface data_mem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              cpu_re;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter view
  modport slave (
    input  cpu_re, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rvalid, host_rdata,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // CPU / host / RAM environment view
  modport master (
    output cpu_re, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rvalid, host_rdata,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Shares one data-RAM port between the CPU Memory stage (priority) and the
// audio host; a starvation counter forces a one-cycle CPU stall for the host.
module data_mem_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic         clk,
  input  logic         rst,
  data_mem_arbiter_if.slave bus
);
  typedef enum logic {S_NORM, S_FORCE} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t            state;
  logic [7:0]        wait_cnt;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;

  logic              cpu_busy;
  logic              gnt;
  logic              stall;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  assign cpu_busy = bus.cpu_re | bus.cpu_we;

  // Port steering is combinational so the CPU never loses a cycle in S_NORM
  always_comb begin
    gnt       = 1'b0;
    stall     = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = bus.cpu_addr;
    mem_wdata = bus.cpu_wdata;
    if (rst) begin
      mem_addr  = '0;
      mem_wdata = '0;
    end else if (state == S_FORCE) begin
      stall = 1'b1;
      if (bus.host_req) begin
        gnt       = 1'b1;
        mem_we    = bus.host_we;
        mem_addr  = bus.host_addr;
        mem_wdata = bus.host_wdata;
      end
    end else if (cpu_busy) begin
      mem_we = bus.cpu_we;
    end else if (bus.host_req) begin
      gnt       = 1'b1;
      mem_we    = bus.host_we;
      mem_addr  = bus.host_addr;
      mem_wdata = bus.host_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_NORM;
      wait_cnt <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= gnt & ~bus.host_we;
      if (gnt && !bus.host_we)
        rdata_q <= bus.mem_rdata;
      case (state)
        S_NORM: begin
          if (bus.host_req && cpu_busy) begin
            if (wait_cnt == WAIT_LAST) begin
              state    <= S_FORCE;
              wait_cnt <= '0;
            end else begin
              wait_cnt <= wait_cnt + 8'd1;
            end
          end else begin
            // Either the host was just served or it is not asking
            wait_cnt <= '0;
          end
        end
        default: begin
          state    <= S_NORM;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.cpu_rdata   = bus.mem_rdata;
  assign bus.cpu_stall   = stall;
  assign bus.host_gnt    = gnt;
  assign bus.host_rvalid = rvalid_q;
  assign bus.host_rdata  = rdata_q;
  assign bus.mem_we      = mem_we;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_wdata   = mem_wdata;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a small combinational-read RAM model.
module tb_data_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic [31:0] ram [0:255];

  always #5 clk = ~clk;

  data_mem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  data_mem_arbiter #(.DATA_W(32), .ADDR_W(32), .MAX_WAIT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.mem_rdata = ram[bus.mem_addr[7:0]];
  always @(posedge clk) if (bus.mem_we) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_all();
    bus.cpu_re = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
  endtask

  task automatic host_read_20(input string p);
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 32'h20;
    settle();
    chk({p, "_gnt"}, 32'(bus.host_gnt), 32'd1);
    chk({p, "_maddr"}, bus.mem_addr, 32'h20);
    chk({p, "_mwe"}, 32'(bus.mem_we), 32'd0);
    tick();
    bus.host_req = 1'b0;
    settle();
    chk({p, "_rvalid"}, 32'(bus.host_rvalid), 32'd1);
    chk({p, "_rdata"}, bus.host_rdata, 32'h1234);
    tick();
    settle();
    chk({p, "_rvalid_drop"}, 32'(bus.host_rvalid), 32'd0);
    tick();
  endtask

  // CPU busy reading 0x40 while the host holds a request; n denied cycles
  task automatic starve(input string p, input int n, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata);
    bus.cpu_re = 1'b1; bus.cpu_addr = 32'h40;
    bus.host_req = 1'b1; bus.host_we = we; bus.host_addr = addr; bus.host_wdata = wdata;
    for (int c = 0; c < n; c++) begin
      settle();
      chk({p, "_deny_gnt"}, 32'(bus.host_gnt), 32'd0);
      chk({p, "_deny_stall"}, 32'(bus.cpu_stall), 32'd0);
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = '0;
    ram[8'h20] = 32'h1234;
    ram[8'h40] = 32'h4040;

    // Reset with requests pending: every output held low, no write issued
    rst = 1'b1;
    bus.cpu_re = 1'b0; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h77; bus.cpu_wdata = 32'hDEAD;
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 32'h78; bus.host_wdata = 32'hBEEF;
    settle();
    chk("rst_stall", 32'(bus.cpu_stall), 32'd0);
    chk("rst_gnt", 32'(bus.host_gnt), 32'd0);
    chk("rst_mwe", 32'(bus.mem_we), 32'd0);
    chk("rst_maddr", bus.mem_addr, 32'd0);
    chk("rst_mwdata", bus.mem_wdata, 32'd0);
    tick();
    tick();
    settle();
    chk("rst_rvalid", 32'(bus.host_rvalid), 32'd0);
    chk("rst_rdata", bus.host_rdata, 32'd0);
    chk("rst_nowr_cpu", ram[8'h77], 32'd0);
    chk("rst_nowr_host", ram[8'h78], 32'd0);
    tick();
    rst = 1'b0;
    idle_all();

    // 1: plain CPU write
    bus.cpu_we = 1'b1; bus.cpu_addr = 32'h10; bus.cpu_wdata = 32'hA5A5A5A5;
    settle();
    chk("t1_mwe", 32'(bus.mem_we), 32'd1);
    chk("t1_maddr", bus.mem_addr, 32'h10);
    chk("t1_mwdata", bus.mem_wdata, 32'hA5A5A5A5);
    chk("t1_gnt", 32'(bus.host_gnt), 32'd0);
    chk("t1_stall", 32'(bus.cpu_stall), 32'd0);
    tick();
    bus.cpu_we = 1'b0;
    settle();
    chk("t1_ram", ram[8'h10], 32'hA5A5A5A5);
    tick();

    // 2: host read in an idle cycle
    host_read_20("t2");

    // 3: starvation -> forced grant on cycle 9
    starve("t3", 8, 1'b1, 32'h30, 32'hCAFE0030);
    settle();
    chk("t3_f_stall", 32'(bus.cpu_stall), 32'd1);
    chk("t3_f_gnt", 32'(bus.host_gnt), 32'd1);
    chk("t3_f_maddr", bus.mem_addr, 32'h30);
    chk("t3_f_mwe", 32'(bus.mem_we), 32'd1);
    chk("t3_f_rvalid", 32'(bus.host_rvalid), 32'd0);
    tick();
    bus.host_req = 1'b0;
    settle();
    chk("t3_c10_stall", 32'(bus.cpu_stall), 32'd0);
    chk("t3_c10_gnt", 32'(bus.host_gnt), 32'd0);
    chk("t3_c10_maddr", bus.mem_addr, 32'h40);
    chk("t3_c10_cpu_rdata", bus.cpu_rdata, 32'h4040);
    chk("t3_ram", ram[8'h30], 32'hCAFE0030);
    chk("t3_no_rvalid", 32'(bus.host_rvalid), 32'd0);
    tick();
    idle_all();

    // 4: host drops request on cycle 5; count restarts on re-assertion
    starve("t4a", 4, 1'b1, 32'h31, 32'hB0B0);
    bus.host_req = 1'b0;
    settle();
    chk("t4_drop_gnt", 32'(bus.host_gnt), 32'd0);
    chk("t4_drop_stall", 32'(bus.cpu_stall), 32'd0);
    tick();
    starve("t4b", 8, 1'b1, 32'h31, 32'hB0B0);
    settle();
    chk("t4_f_stall", 32'(bus.cpu_stall), 32'd1);
    chk("t4_f_gnt", 32'(bus.host_gnt), 32'd1);
    chk("t4_f_maddr", bus.mem_addr, 32'h31);
    tick();
    bus.host_req = 1'b0;
    settle();
    chk("t4_after_stall", 32'(bus.cpu_stall), 32'd0);
    tick();
    idle_all();

    // Forced cycle with no host request is wasted; CPU write waits a cycle
    starve("t7", 8, 1'b1, 32'h33, 32'h3333);
    bus.host_req = 1'b0; bus.cpu_re = 1'b0; bus.cpu_we = 1'b1;
    bus.cpu_addr = 32'h50; bus.cpu_wdata = 32'h5050;
    settle();
    chk("t7_f_stall", 32'(bus.cpu_stall), 32'd1);
    chk("t7_f_gnt", 32'(bus.host_gnt), 32'd0);
    chk("t7_f_mwe", 32'(bus.mem_we), 32'd0);
    tick();
    settle();
    chk("t7_c10_stall", 32'(bus.cpu_stall), 32'd0);
    chk("t7_c10_mwe", 32'(bus.mem_we), 32'd1);
    chk("t7_c10_maddr", bus.mem_addr, 32'h50);
    tick();
    idle_all();
    settle();
    chk("t7_ram", ram[8'h50], 32'h5050);
    chk("t7_ram33", ram[8'h33], 32'd0);
    tick();

    // 5: reset during the rvalid cycle discards it
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 32'h20;
    settle();
    chk("t5_gnt", 32'(bus.host_gnt), 32'd1);
    tick();
    bus.host_req = 1'b0;
    rst = 1'b1;
    tick();
    settle();
    chk("t5_rvalid", 32'(bus.host_rvalid), 32'd0);
    chk("t5_rdata", bus.host_rdata, 32'd0);
    chk("t5_stall", 32'(bus.cpu_stall), 32'd0);
    tick();
    rst = 1'b0;

    // Reset landing on the forced cycle: no host write, back to S_NORM
    starve("t5f", 8, 1'b1, 32'h34, 32'h3434);
    rst = 1'b1;
    settle();
    chk("t5f_rst_stall", 32'(bus.cpu_stall), 32'd0);
    chk("t5f_rst_gnt", 32'(bus.host_gnt), 32'd0);
    chk("t5f_rst_mwe", 32'(bus.mem_we), 32'd0);
    chk("t5f_rst_maddr", bus.mem_addr, 32'd0);
    tick();
    rst = 1'b0;
    settle();
    chk("t5f_norm_stall", 32'(bus.cpu_stall), 32'd0);
    chk("t5f_norm_gnt", 32'(bus.host_gnt), 32'd0);
    chk("t5f_norm_maddr", bus.mem_addr, 32'h40);
    tick();
    idle_all();
    settle();
    chk("t5f_ram", ram[8'h34], 32'd0);
    tick();
    host_read_20("t5r");

    // 6: CPU busy on alternate cycles, host request held throughout
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 32'h20;
    bus.cpu_addr = 32'h40;
    for (int k = 0; k < 20; k++) begin
      bus.cpu_re = (k % 2 == 0);
      settle();
      chk("t6_stall", 32'(bus.cpu_stall), 32'd0);
      chk("t6_gnt", 32'(bus.host_gnt), (k % 2 == 0) ? 32'd0 : 32'd1);
      if (k > 0 && (k % 2 == 0)) begin
        chk("t6_rvalid", 32'(bus.host_rvalid), 32'd1);
        chk("t6_rdata", bus.host_rdata, 32'h1234);
      end
      tick();
    end
    idle_all();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
